// File: rtl/gba_line_capture_if.sv
// rtl/gba_line_capture_if.sv - GBA LCD capture bus: GBA pins, reader request, line-memory write and status
interface gba_line_capture_if;
    logic        gba_dclk;
    logic        gba_hsync;
    logic        gba_vsync;
    logic [14:0] gba_data;
    logic        next_line;
    logic        mem_wr_en;
    logic [9:0]  mem_wr_addr;
    logic [23:0] mem_wr_data;
    logic [1:0]  cur_slot;
    logic        same_line;
    logic        new_frame;
    logic        pxl_err;

    modport master (
        output gba_dclk, gba_hsync, gba_vsync, gba_data, next_line,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, cur_slot, same_line, new_frame, pxl_err
    );

    modport slave (
        input  gba_dclk, gba_hsync, gba_vsync, gba_data, next_line,
        output mem_wr_en, mem_wr_addr, mem_wr_data, cur_slot, same_line, new_frame, pxl_err
    );
endinterface

// File: rtl/gba_line_capture.sv
// rtl/gba_line_capture.sv - GBA LCD line capture into a four-slot line memory
module gba_line_capture #(
    parameter int H_PIXELS    = 240,
    parameter int V_LINES     = 160,
    parameter int SYNC_STAGES = 2
) (
    input  logic              pxl_clk_i,
    input  logic              rst_n_i,
    gba_line_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    localparam logic [7:0] H_LAST = 8'(H_PIXELS - 1);
    localparam logic [7:0] H_END  = 8'(H_PIXELS);
    localparam logic [7:0] V_LAST = 8'(V_LINES - 1);
    localparam logic [7:0] V_END  = 8'(V_LINES);

    // {vsync, hsync, dclk, data} share one chain so data stays aligned with its strobe
    logic [SYNC_STAGES-1:0][17:0] sync_q;
    logic [SYNC_STAGES:0][17:0]   sync_chain;
    logic [17:0]                  sync_last;
    logic [2:0]                   ctl_prev_q;
    logic                         dclk_rise_q;
    logic                         hs_fall_q;
    logic                         vs_fall_q;
    logic [14:0]                  pix_q;

    assign sync_chain = {sync_q, bus.gba_vsync, bus.gba_hsync, bus.gba_dclk, bus.gba_data};
    assign sync_last  = sync_q[SYNC_STAGES-1];

    always_ff @(posedge pxl_clk_i) begin
        if (!rst_n_i) begin
            sync_q      <= '0;
            ctl_prev_q  <= '0;
            dclk_rise_q <= 1'b0;
            hs_fall_q   <= 1'b0;
            vs_fall_q   <= 1'b0;
            pix_q       <= '0;
        end else begin
            sync_q      <= sync_chain[SYNC_STAGES-1:0];
            ctl_prev_q  <= sync_last[17:15];
            dclk_rise_q <= sync_last[15] & ~ctl_prev_q[0];
            hs_fall_q   <= ~sync_last[16] & ctl_prev_q[1];
            vs_fall_q   <= ~sync_last[17] & ctl_prev_q[2];
            pix_q       <= sync_last[14:0];
        end
    end

    state_t      state_q;
    logic [7:0]  x_q, wr_line_q, rd_line_q;
    logic [1:0]  wr_slot_q, cur_slot_q;
    logic        err_q, new_frame_q;
    logic        cap_vld_q;
    logic [9:0]  cap_addr_q;
    logic [23:0] cap_rgb_q;
    logic        mem_wr_en_q;
    logic [9:0]  mem_wr_addr_q;
    logic [23:0] mem_wr_data_q;

    logic        active, pix_ok, pix_long, hs_short, line_done;
    logic        same_line, advance, overrun, err_d;
    logic [7:0]  x_d, wr_line_d, rd_line_d;
    logic [1:0]  wr_slot_d, cur_slot_d;
    logic [23:0] rgb;

    always_comb begin
        active    = (state_q == ACTIVE);
        // an hsync edge landing on the same cycle as a dot clock edge wins; that pixel is dropped
        pix_ok    = active && dclk_rise_q && !hs_fall_q && (x_q < H_END);
        pix_long  = active && dclk_rise_q && !hs_fall_q && (x_q == H_END);
        hs_short  = active && hs_fall_q && (x_q != 8'd0) && (x_q < H_END);
        line_done = hs_short || (pix_ok && (x_q == H_LAST));
        same_line = (({1'b0, rd_line_q} + 9'd1) >= {1'b0, wr_line_q}) || (rd_line_q == V_LAST);
        advance   = bus.next_line && !same_line;

        x_d = x_q;
        if (hs_fall_q) begin
            x_d = 8'd0;
        end else if (pix_ok) begin
            x_d = x_q + 8'd1;
        end
        wr_line_d  = line_done ? wr_line_q + 8'd1 : wr_line_q;
        rd_line_d  = advance ? rd_line_q + 8'd1 : rd_line_q;
        wr_slot_d  = line_done ? wr_slot_q + 2'd1 : wr_slot_q;
        cur_slot_d = advance ? cur_slot_q + 2'd1 : cur_slot_q;
        overrun    = line_done && (wr_slot_d == (cur_slot_d - 2'd1));
        err_d      = err_q | pix_long | hs_short | overrun;
        rgb        = {pix_q[4:0], pix_q[4:2], pix_q[9:5], pix_q[9:7], pix_q[14:10], pix_q[14:12]};
    end

    always_ff @(posedge pxl_clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            x_q         <= '0;
            wr_line_q   <= '0;
            rd_line_q   <= '0;
            wr_slot_q   <= '0;
            cur_slot_q  <= '0;
            err_q       <= 1'b0;
            new_frame_q <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_addr_q  <= '0;
            cap_rgb_q   <= '0;
        end else if (vs_fall_q) begin
            state_q     <= ACTIVE;
            x_q         <= '0;
            wr_line_q   <= '0;
            rd_line_q   <= '0;
            wr_slot_q   <= '0;
            cur_slot_q  <= '0;
            new_frame_q <= 1'b0;
            cap_vld_q   <= 1'b0;
        end else begin
            x_q         <= x_d;
            wr_line_q   <= wr_line_d;
            rd_line_q   <= rd_line_d;
            wr_slot_q   <= wr_slot_d;
            cur_slot_q  <= cur_slot_d;
            err_q       <= err_d;
            new_frame_q <= line_done && (wr_line_q == 8'd0);
            cap_vld_q   <= pix_ok;
            if (pix_ok) begin
                cap_addr_q <= {wr_slot_q, x_q};
                cap_rgb_q  <= rgb;
            end
            if (active && (wr_line_d == V_END)) begin
                state_q <= DONE;
            end
        end
    end

    always_ff @(posedge pxl_clk_i) begin
        if (!rst_n_i) begin
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
        end else begin
            mem_wr_en_q <= cap_vld_q;
            if (cap_vld_q) begin
                mem_wr_addr_q <= cap_addr_q;
                mem_wr_data_q <= cap_rgb_q;
            end
        end
    end

    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.mem_wr_addr = mem_wr_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.cur_slot    = cur_slot_q;
    assign bus.same_line   = same_line;
    assign bus.new_frame   = new_frame_q;
    assign bus.pxl_err     = err_q;
endmodule

// File: doc/gba_line_capture.md
GBA_LINE_CAPTURE -- requirements
Module: gbaLineCapture

Interface
REQ-001 The parameter H_PIXELS SHALL default to 240 and sets the active pixels captured per GBA line.
REQ-002 The parameter V_LINES SHALL default to 160 and sets the active lines captured per GBA frame.
REQ-003 The parameter SYNC_STAGES SHALL default to 2 and sets the synchroniser depth applied to every GBA input.
REQ-004 pxlClk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 rstN  in  1  SHALL be the reset, synchronous and active-low.
REQ-006 gbaDclk  in  1  SHALL be the asynchronous GBA LCD dot clock; pixel data is valid on its rising edge.
REQ-007 gbaHsync  in  1  SHALL be the asynchronous line sync, active-low.
REQ-008 gbaVsync  in  1  SHALL be the asynchronous frame sync, active-low.
REQ-009 gbaData  in  15  SHALL be the pixel data, {B[4:0],G[4:0],R[4:0]}.
REQ-010 nextLine  in  1  SHALL be a one-cycle request from the image generator to advance its current read line.
REQ-011 memWrEn  out  1  SHALL be the line-memory write strobe.
REQ-012 memWrAddr  out  10  SHALL be the write address {slot[1:0], x[7:0]}.
REQ-013 memWrData  out  24  SHALL be the write data {R8,G8,B8}.
REQ-014 curSlot  out  2  SHALL be the slot holding the reader's current line; prev = curSlot-1 and next = curSlot+1, both mod 4.
REQ-015 sameLine  out  1  SHALL be high while the line after the current read line is not yet complete.
REQ-016 newFrame  out  1  SHALL be a one-cycle pulse marking that frame line 0 is complete.
REQ-017 pxlErr  out  1  SHALL be a sticky flag for short, long or overrun line events.

Function
REQ-018 Each GBA input SHALL pass through SYNC_STAGES flops, followed by one edge-detect register for gbaDclk, gbaHsync and gbaVsync.
REQ-019 A synchronised gbaDclk rising edge SHALL capture the equally delayed gbaData; memWrEn SHALL pulse one cycle later, SYNC_STAGES+2 cycles after the first pxlClk edge that samples gbaDclk high.
REQ-020 Colour expansion SHALL be c8 = {c5, c5[4:2]} per channel; 5'h1F maps to 8'hFF and 5'h00 maps to 8'h00.
REQ-021 The x counter (8 bit) SHALL start at 0 after each hsync falling edge and increment after each write.
REQ-022 Pixels arriving while x == H_PIXELS SHALL NOT be written, and SHALL set pxlErr.
REQ-023 A line SHALL complete on the write with x == H_PIXELS-1, or on an hsync falling edge that arrives while 0 < x < H_PIXELS.
REQ-024 The hsync-triggered completion in REQ-023 is a short line and SHALL set pxlErr.
REQ-025 An hsync falling edge with x == 0 or x == H_PIXELS SHALL only re-arm x.
REQ-026 On line completion, wrLine (8 bit) SHALL increment and wrSlot SHALL advance mod 4.
REQ-027 Lines with wrLine >= V_LINES SHALL NOT be written.
REQ-028 The write-slot state machine SHALL use the states IDLE (await vsync), ACTIVE (capturing) and DONE (V_LINES complete, writes blocked).
REQ-029 State transitions SHALL be: vsync falling edge -> ACTIVE from any state; wrLine == V_LINES -> DONE.
REQ-030 A vsync falling edge SHALL clear wrLine, rdLine, x, wrSlot and curSlot to 0.
REQ-031 newFrame SHALL pulse on the cycle wrLine goes 0 -> 1.
REQ-032 sameLine SHALL be combinationally (rdLine+1 >= wrLine), or rdLine == V_LINES-1.
REQ-033 nextLine with sameLine low SHALL increment rdLine and curSlot; nextLine with sameLine high SHALL be ignored.
REQ-034 Overrun: a line completion that would make wrSlot == curSlot-1 (the prev slot) SHALL set pxlErr; the write still proceeds.
REQ-035 If nextLine and a line completion coincide, both SHALL take effect in that same cycle.
REQ-036 If a vsync falling edge and a dclk edge coincide, the vsync clear SHALL win and the pixel SHALL be dropped.

Reset
REQ-037 While rstN is low on a pxlClk edge, every output SHALL go to 0 except sameLine, which SHALL be 1.
REQ-038 Reset SHALL put the state machine in IDLE, clear all counters and synchroniser flops, and clear pxlErr.
REQ-039 Reset asserted mid-line SHALL abort the line with no further memWrEn until the next vsync falling edge.
REQ-040 pxlErr SHALL clear only on reset.

Verification
REQ-041 The bench SHALL cover a full frame: vsync, then 160 lines of 240 pixels with gbaData = 15'h7FFF -> 38400 writes of 24'hFFFFFF, one newFrame pulse, pxlErr = 0.
REQ-042 The bench SHALL cover a short line of 200 pixels then hsync -> line completes, wrSlot advances, pxlErr = 1.
REQ-043 The bench SHALL cover 245 pixels in one line -> exactly 240 writes at addresses {slot, 0..239}, pxlErr = 1.
REQ-044 The bench SHALL cover a reader stall: nextLine while wrLine = rdLine+1 -> ignored with curSlot unchanged; after the next completion, nextLine advances curSlot by 1.
REQ-045 The bench SHALL cover rstN low for 1 cycle at x = 100 -> outputs reset, sameLine = 1, no writes until the next vsync.
REQ-046 The bench SHALL cover a vsync falling edge coincident with a dclk edge -> no write, all counters at 0.
